// File: rtl/input_conditioner.sv
// Switch/button input conditioner: synchroniser, counter debounce,
// mode-selected edge pulses with auto-repeat, sticky pend/ovf flags.
// Ports: clk, reset_n (async active-low), din (raw inputs),
//   mode (00 rise, 01 fall, 10 both, 11 rise+repeat), ack (per channel);
//   level (debounced), pulse (1-cycle event), pend/ovf (sticky),
//   any_pend (OR of pend).
module input_conditioner #(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] din,
    input  logic [1:0]      mode,
    input  logic [N_CH-1:0] ack,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pulse,
    output logic [N_CH-1:0] pend,
    output logic [N_CH-1:0] ovf,
    output logic            any_pend
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int RPMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                           REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW = $clog2(RPMAX + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [RPW-1:0] RP_DELAY  = RPW'(REPEAT_DELAY);
    localparam logic [RPW-1:0] RP_PERIOD = RPW'(REPEAT_PERIOD);
    localparam logic [RPW-1:0] RP_ONE    = RPW'(1);

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  s;

    logic [N_CH-1:0][DBW-1:0] db_cnt_q, db_cnt_d;
    logic [N_CH-1:0][RPW-1:0] rep_cnt_q, rep_cnt_d;
    logic [N_CH-1:0]          level_q, level_d;
    logic [N_CH-1:0]          pulse_q, pulse_d;
    logic [N_CH-1:0]          pend_q, pend_d;
    logic [N_CH-1:0]          ovf_q, ovf_d;
    logic [1:0]               mode_q;

    logic [N_CH-1:0] rise, fall, rep_fire;
    logic            mode_chg;

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = level_d & ~level_q;
    assign fall     = ~level_d & level_q;
    assign mode_chg = (mode != mode_q);

    // Debounce: level follows s only after DB_CYCLES consecutive
    // mismatching cycles; any agreeing cycle restarts the count.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < N_CH; i++) begin
            if (s[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                level_d[i]  = s[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Repeat counter is a countdown; zero means idle. A release on the
    // same edge a repeat is due wins, so no pulse accompanies release.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_fire  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (mode == 2'b11 && rise[i]) begin
                rep_cnt_d[i] = RP_DELAY;
            end else if (mode_chg || !level_d[i]) begin
                rep_cnt_d[i] = '0;
            end else if (rep_cnt_q[i] == RP_ONE) begin
                rep_fire[i]  = 1'b1;
                rep_cnt_d[i] = RP_PERIOD;
            end else if (rep_cnt_q[i] != '0) begin
                rep_cnt_d[i] = rep_cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        pulse_d = '0;
        unique case (mode)
            2'b00: pulse_d = rise;
            2'b01: pulse_d = fall;
            2'b10: pulse_d = rise | fall;
            2'b11: pulse_d = rise | rep_fire;
        endcase
    end

    // A simultaneous ack consumes the old event while the new one
    // becomes pending, hence set wins and overflow clears.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < N_CH; i++) begin
            if (pulse_q[i] && ack[i]) begin
                pend_d[i] = 1'b1;
                ovf_d[i]  = 1'b0;
            end else if (pulse_q[i]) begin
                if (pend_q[i]) ovf_d[i] = 1'b1;
                else           pend_d[i] = 1'b1;
            end else if (ack[i]) begin
                pend_d[i] = 1'b0;
                ovf_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
            level_q   <= '0;
            pulse_q   <= '0;
            pend_q    <= '0;
            ovf_q     <= '0;
            mode_q    <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], din};
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            mode_q    <= mode;
        end
    end

    assign level    = level_q;
    assign pulse    = pulse_q;
    assign pend     = pend_q;
    assign ovf      = ovf_q;
    assign any_pend = |pend_q;

endmodule
